// File: rtl/md5_round_sequencer.sv
// md5_round_sequencer: flow-controlled per-round schedule for the iterative
// MD5 datapath. Walks rounds 0..NUM_ROUNDS-1 on start and presents rotate
// amount, message word index, boolean function select and K per round.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; all schedule outputs held at zero
// ST_RUN  | presenting round_q on the stream, advancing on handshake
module md5_round_sequencer #(
    parameter int S_WIDTH    = 5,
    parameter int NUM_ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic [5:0]         round_o,
    output logic [S_WIDTH-1:0] shift_o,
    output logic [3:0]         g_idx_o,
    output logic [1:0]         fsel_o,
    output logic [31:0]        k_const_o,
    output logic               last_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS - 1);

    state_t             state_q, state_d;
    logic [5:0]         round_q, round_d;
    logic [S_WIDTH-1:0] shift_q;
    logic [3:0]         g_idx_q;
    logic [1:0]         fsel_q;
    logic [31:0]        k_const_q;
    logic               last_q;
    logic               done_q, done_d;
    logic               run_d;

    // Rotate amount: one 4-entry set per 16-round group, indexed by round mod 4.
    function automatic logic [4:0] shift_lut(input logic [5:0] r);
        logic [4:0] s;
        case ({r[5:4], r[1:0]})
            4'h0: s = 5'd7;
            4'h1: s = 5'd12;
            4'h2: s = 5'd17;
            4'h3: s = 5'd22;
            4'h4: s = 5'd5;
            4'h5: s = 5'd9;
            4'h6: s = 5'd14;
            4'h7: s = 5'd20;
            4'h8: s = 5'd4;
            4'h9: s = 5'd11;
            4'hA: s = 5'd16;
            4'hB: s = 5'd23;
            4'hC: s = 5'd6;
            4'hD: s = 5'd10;
            4'hE: s = 5'd15;
            default: s = 5'd21;
        endcase
        return s;
    endfunction

    // Message word index; all arithmetic is mod 16 so only round[3:0] matters.
    function automatic logic [3:0] g_lut(input logic [5:0] r);
        logic [3:0] r4;
        logic [3:0] g;
        r4 = r[3:0];
        case (r[5:4])
            2'd0:    g = r4;
            2'd1:    g = (r4 * 4'd5) + 4'd1;
            2'd2:    g = (r4 * 4'd3) + 4'd5;
            default: g = r4 * 4'd7;
        endcase
        return g;
    endfunction

    // K[r] = floor(|sin(r+1)| * 2^32).
    function automatic logic [31:0] k_lut(input logic [5:0] r);
        logic [31:0] k;
        case (r)
            6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;
            6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;
            6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;
            6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;
            6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;
            6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;
            6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;
            6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;
            6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;
            6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;
            6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;
            6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;
            6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;
            6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;
            6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;
            6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;
            6'd62: k = 32'h2ad7d2bb;  default: k = 32'heb86d391;
        endcase
        return k;
    endfunction

    // Next state, next round and the completion pulse; abort beats both
    // start (in IDLE) and a concurrent handshake (in RUN).
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = ST_RUN;
                    round_d = 6'd0;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (out_ready_i) begin
                    if (round_q == LAST_RND) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        run_d = (state_d == ST_RUN);
    end

    // Register state and the per-round fields together so they change on the
    // same edge as the round index; everything is forced to zero outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            round_q   <= 6'd0;
            shift_q   <= '0;
            g_idx_q   <= 4'd0;
            fsel_q    <= 2'd0;
            k_const_q <= 32'd0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (run_d) begin
                round_q   <= round_d;
                shift_q   <= S_WIDTH'(shift_lut(round_d));
                g_idx_q   <= g_lut(round_d);
                fsel_q    <= round_d[5:4];
                k_const_q <= k_lut(round_d);
                last_q    <= (round_d == LAST_RND);
            end else begin
                round_q   <= 6'd0;
                shift_q   <= '0;
                g_idx_q   <= 4'd0;
                fsel_q    <= 2'd0;
                k_const_q <= 32'd0;
                last_q    <= 1'b0;
            end
        end
    end

    assign out_valid_o = (state_q == ST_RUN);
    assign busy_o      = (state_q == ST_RUN);
    assign round_o     = round_q;
    assign shift_o     = shift_q;
    assign g_idx_o     = g_idx_q;
    assign fsel_o      = fsel_q;
    assign k_const_o   = k_const_q;
    assign last_o      = last_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_md5_round_sequencer.sv
// Testbench for md5_round_sequencer: a 64-round/5-bit instance and a
// 16-round/8-bit instance, checked against a behavioural schedule model.
module tb_md5_round_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 0, abort_a = 0, ready_a = 0;
    logic        a_valid, a_last, a_busy, a_done;
    logic [5:0]  a_round;
    logic [4:0]  a_shift;
    logic [3:0]  a_g;
    logic [1:0]  a_fsel;
    logic [31:0] a_k;

    logic        start_b = 0, abort_b = 0, ready_b = 0;
    logic        b_valid, b_last, b_busy, b_done;
    logic [5:0]  b_round;
    logic [7:0]  b_shift;
    logic [3:0]  b_g;
    logic [1:0]  b_fsel;
    logic [31:0] b_k;

    md5_round_sequencer #(.S_WIDTH(5), .NUM_ROUNDS(64)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a),
        .out_ready_i(ready_a), .out_valid_o(a_valid), .round_o(a_round),
        .shift_o(a_shift), .g_idx_o(a_g), .fsel_o(a_fsel), .k_const_o(a_k),
        .last_o(a_last), .busy_o(a_busy), .done_o(a_done));

    md5_round_sequencer #(.S_WIDTH(8), .NUM_ROUNDS(16)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
        .out_ready_i(ready_b), .out_valid_o(b_valid), .round_o(b_round),
        .shift_o(b_shift), .g_idx_o(b_g), .fsel_o(b_fsel), .k_const_o(b_k),
        .last_o(b_last), .busy_o(b_busy), .done_o(b_done));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: per instance, whether a run is active, which round
    // is on offer, and whether the completion pulse is due this cycle.
    bit m_act  [2];
    int m_rnd  [2];
    bit m_done [2];
    int nr     [2] = '{64, 16};

    localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    function automatic logic [31:0] model_k(int r);
        real    s;
        longint v;
        s = $sin(real'(r + 1));
        if (s < 0.0) s = -s;
        v = longint'($floor(s * 4294967296.0));
        return v[31:0];
    endfunction

    function automatic logic [7:0] model_shift(int r);
        return 8'(SH[(r / 16) * 4 + (r % 4)]);
    endfunction

    function automatic logic [3:0] model_g(int r);
        case (r / 16)
            0:       return 4'(r % 16);
            1:       return 4'((5 * r + 1) % 16);
            2:       return 4'((3 * r + 5) % 16);
            default: return 4'((7 * r) % 16);
        endcase
    endfunction

    // {valid, round, shift(8), g, fsel, k, last, busy, done}
    function automatic logic [55:0] model_vec(int i);
        if (!m_act[i]) return {55'd0, m_done[i]};
        return {1'b1, 6'(m_rnd[i]), model_shift(m_rnd[i]), model_g(m_rnd[i]),
                2'(m_rnd[i] / 16), model_k(m_rnd[i]), (m_rnd[i] == nr[i] - 1),
                1'b1, m_done[i]};
    endfunction

    function automatic logic [55:0] act_vec(int i);
        if (i == 0)
            return {a_valid, a_round, 3'b000, a_shift, a_g, a_fsel, a_k, a_last, a_busy, a_done};
        return {b_valid, b_round, b_shift, b_g, b_fsel, b_k, b_last, b_busy, b_done};
    endfunction

    task automatic model_step(int i, bit st, bit ab, bit rd);
        m_done[i] = 1'b0;
        if (!m_act[i]) begin
            if (st && !ab) begin
                m_act[i] = 1'b1;
                m_rnd[i] = 0;
            end
        end else if (ab) begin
            m_act[i] = 1'b0;
        end else if (rd) begin
            if (m_rnd[i] == nr[i] - 1) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b1;
            end else begin
                m_rnd[i]++;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_rnd[i]  = 0;
            m_done[i] = 1'b0;
        end
    endtask

    // Advance one clock: inputs are sampled at the rising edge, outputs are
    // observed on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(0, start_a, abort_a, ready_a);
        model_step(1, start_b, abort_b, ready_b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (act_vec(0) !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", act_vec(0));
        end
        n_checks++;
        if (act_vec(1) !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", act_vec(1));
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        int hs = 0, dn = 0, done_cyc = -1;
        start_a = 1; ready_a = 1;
        tick();
        start_a = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            n_checks++;
            if (act_vec(0) !== model_vec(0)) begin
                n_fail++;
                $display("FAIL full_run cyc %0d: got %h want %h", cyc, act_vec(0), model_vec(0));
            end
            if (a_valid && a_round == 6'd0) begin
                n_checks++;
                if ({a_shift, a_g, a_fsel, a_k} !== {5'd7, 4'd0, 2'd0, 32'hd76aa478}) begin
                    n_fail++;
                    $display("FAIL round0_fields: got %h", {a_shift, a_g, a_fsel, a_k});
                end
            end
            if (a_valid && a_round == 6'd17) begin
                n_checks++;
                if ({a_shift, a_g, a_fsel} !== {5'd9, 4'd6, 2'd1}) begin
                    n_fail++;
                    $display("FAIL round17_fields: got %h", {a_shift, a_g, a_fsel});
                end
            end
            if (a_valid && a_round == 6'd24) begin
                n_checks++;
                if ({a_shift, a_g, a_k} !== {5'd5, 4'd9, 32'h21e1cde6}) begin
                    n_fail++;
                    $display("FAIL round24_fields: got %h", {a_shift, a_g, a_k});
                end
            end
            if (a_valid && a_round == 6'd63) begin
                n_checks++;
                if ({a_shift, a_g, a_fsel, a_k, a_last} !== {5'd21, 4'd9, 2'd3, 32'heb86d391, 1'b1}) begin
                    n_fail++;
                    $display("FAIL round63_fields: got %h", {a_shift, a_g, a_fsel, a_k, a_last});
                end
            end
            if (a_valid && ready_a) hs++;
            if (a_done) begin
                dn++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            tick();
        end
        n_checks++;
        if (hs != 64 || dn != 1 || done_cyc != 64) begin
            n_fail++;
            $display("FAIL full_run_count: handshakes %0d dones %0d done_cyc %0d want 64 1 64", hs, dn, done_cyc);
        end
    endtask

    task automatic test_back_pressure();
        int acc[$];
        int stall = 0, r10 = 0, bad = 0;
        bit seen10 = 0, got_done = 0;
        start_a = 1; ready_a = 1;
        tick();
        start_a = 0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            n_checks++;
            if (act_vec(0) !== model_vec(0)) begin
                n_fail++;
                $display("FAIL back_pressure cyc %0d: got %h want %h", cyc, act_vec(0), model_vec(0));
            end
            if (a_valid && a_round == 6'd10 && !seen10) begin
                seen10 = 1;
                stall  = 3;
            end
            if (stall > 0) begin
                ready_a = 0;
                stall--;
            end else begin
                ready_a = ($urandom_range(3) != 0);
            end
            if (a_valid && a_round == 6'd10) r10++;
            if (a_valid && ready_a) acc.push_back(int'(a_round));
            if (a_done) got_done = 1;
            else tick();
        end
        ready_a = 1;
        for (int i = 0; i < acc.size(); i++) if (acc[i] != i) bad++;
        n_checks++;
        if (acc.size() != 64 || bad != 0 || !got_done) begin
            n_fail++;
            $display("FAIL back_pressure_seq: handshakes %0d out_of_order %0d done %0d want 64 0 1", acc.size(), bad, got_done);
        end
        n_checks++;
        if (r10 < 4) begin
            n_fail++;
            $display("FAIL back_pressure_hold: round10 cycles %0d want >=4", r10);
        end
    endtask

    task automatic test_small_config();
        int hs = 0;
        bit got_done = 0, saw_last = 0;
        start_b = 1; ready_b = 1;
        tick();
        start_b = 0;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            n_checks++;
            if (act_vec(1) !== model_vec(1)) begin
                n_fail++;
                $display("FAIL small_cfg cyc %0d: got %h want %h", cyc, act_vec(1), model_vec(1));
            end
            if (b_valid && b_round == 6'd15) begin
                saw_last = 1;
                n_checks++;
                if ({b_shift, b_last} !== {8'd22, 1'b1}) begin
                    n_fail++;
                    $display("FAIL small_cfg_last: got %h want %h", {b_shift, b_last}, {8'd22, 1'b1});
                end
            end
            if (b_done) begin
                got_done = 1;
                n_checks++;
                if (b_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL small_cfg_busy: got %b want 0", b_busy);
                end
            end else begin
                ready_b = ($urandom_range(2) != 0);
                if (b_valid && ready_b) hs++;
                tick();
            end
        end
        ready_b = 0;
        n_checks++;
        if (hs != 16 || !got_done || !saw_last) begin
            n_fail++;
            $display("FAIL small_cfg_count: handshakes %0d done %0d last %0d want 16 1 1", hs, got_done, saw_last);
        end
    endtask

    task automatic test_abort();
        int dn = 0;
        bit reached = 0;
        start_a = 1; ready_a = 1;
        tick();
        start_a = 0;
        for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
            if (a_valid && a_round == 6'd30) reached = 1;
            else tick();
        end
        ready_a = 0; abort_a = 1;
        tick();
        abort_a = 0;
        n_checks++;
        if (a_valid !== 1'b0 || act_vec(0) !== model_vec(0) || !reached) begin
            n_fail++;
            $display("FAIL abort_valid: got %h want %h reached %0d", act_vec(0), model_vec(0), reached);
        end
        for (int i = 0; i < 4; i++) begin
            if (a_done) dn++;
            tick();
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses want 0", dn);
        end
        start_a = 1; ready_a = 1;
        tick();
        start_a = 0;
        n_checks++;
        if ({a_valid, a_round} !== {1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL abort_restart: got %h want %h", {a_valid, a_round}, {1'b1, 6'd0});
        end
        abort_a = 1;
        tick();
        abort_a = 0;
    endtask

    task automatic test_start_abort_idle();
        start_a = 1; abort_a = 1;
        tick();
        start_a = 0; abort_a = 0;
        n_checks++;
        if (a_busy !== 1'b0 || act_vec(0) !== model_vec(0)) begin
            n_fail++;
            $display("FAIL start_abort_idle: got %h want %h", act_vec(0), model_vec(0));
        end
    endtask

    task automatic test_start_in_run_and_done();
        int hs = 0;
        bit got_done = 0;
        start_a = 1; ready_a = 1;
        tick();
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            n_checks++;
            if (act_vec(0) !== model_vec(0)) begin
                n_fail++;
                $display("FAIL start_in_run cyc %0d: got %h want %h", cyc, act_vec(0), model_vec(0));
            end
            if (a_done) begin
                got_done = 1;
            end else begin
                ready_a = ($urandom_range(3) != 0);
                if (a_valid && ready_a) hs++;
                tick();
            end
        end
        ready_a = 1;
        tick();
        start_a = 0;
        n_checks++;
        if (hs != 64 || !got_done || {a_valid, a_round} !== {1'b1, 6'd0}) begin
            n_fail++;
            $display("FAIL start_in_done: handshakes %0d done %0d next %h want 64 1 %h",
                     hs, got_done, {a_valid, a_round}, {1'b1, 6'd0});
        end
        abort_a = 1;
        tick();
        abort_a = 0;
    endtask

    task automatic test_async_reset();
        bit reached = 0;
        start_a = 1; ready_a = 1;
        tick();
        start_a = 0;
        for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
            if (a_valid && a_round == 6'd40) reached = 1;
            else tick();
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (act_vec(0) !== 56'd0 || !reached) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0 reached %0d", act_vec(0), reached);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (act_vec(0) !== model_vec(0)) begin
                n_fail++;
                $display("FAIL reset_idle %0d: got %h want %h", i, act_vec(0), model_vec(0));
            end
        end
        start_a = 1;
        tick();
        start_a = 0;
        n_checks++;
        if ({a_valid, a_round, a_shift} !== {1'b1, 6'd0, 5'd7}) begin
            n_fail++;
            $display("FAIL reset_restart: got %h want %h", {a_valid, a_round, a_shift}, {1'b1, 6'd0, 5'd7});
        end
        abort_a = 1;
        tick();
        abort_a = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_run();
        test_back_pressure();
        test_small_config();
        test_abort();
        test_start_abort_idle();
        test_start_in_run_and_done();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
